// File: rtl/cla_sub_pipe_24bit_pkg.sv
// Shared constants and helpers for the pipelined CLA subtractor.
// Holds the default operand width, the per-stage half-width computation
// and the borrow convention (borrow is the inverted carry out of A + ~B + 1).
package cla_sub_pipe_24bit_pkg;

  localparam int CLA_W_DEFAULT = 24;

  // Bits evaluated by each pipeline stage.
  function automatic int cla_half(input int w);
    return w / 2;
  endfunction

  // A subtraction done as A + ~B + 1 borrows exactly when it produces no carry.
  function automatic logic borrow_from_carry(input logic carry_out);
    return ~carry_out;
  endfunction

endpackage

// File: rtl/cla_sub_pipe_24bit_cla_block.sv
// Combinational N-bit carry-lookahead adder slice.
// Generate g = a & b, propagate p = a | b, carry c[i+1] = g[i] | p[i] & c[i].
// The caller forms any operand inversion; this block only adds.
module cla_block #(
  parameter int N = 12
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N-1:0] g_s;
  logic [N-1:0] p_s;
  logic [N:0]   c_s;

  assign g_s = i_a & i_b;
  assign p_s = i_a | i_b;

  // Carry chain expanded from the generate/propagate terms.
  always_comb begin
    c_s    = '0;
    c_s[0] = i_cin;
    for (int i = 0; i < N; i++) begin
      c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
    end
  end

  assign o_sum  = i_a ^ i_b ^ c_s[N-1:0];
  assign o_cout = c_s[N];

endmodule

// File: rtl/cla_sub_pipe_24bit.sv
// Two-stage pipelined carry-lookahead subtractor: o_result = {borrow, i_min - i_sub}.
// Stage 1 subtracts the low half (carry-in 1), stage 2 the high half using the
// registered mid carry. Valid/ready handshake on both sides, no bubble on a full pipe.
// Optional macro CLA_SUB_OVF_EN: adds a registered signed-overflow flag on o_ovf;
// without it o_ovf is tied low and no flop is built.
module cla_sub_pipe_24bit
  import cla_sub_pipe_24bit_pkg::*;
#(
  parameter int WIDTH = CLA_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_ovf
);

  localparam int HALF = cla_half(WIDTH);

  // Handshake control
  logic s1_adv_s;
  logic accept_s;

  // Stage 1 datapath and registers
  logic [HALF-1:0] b_lo_inv_s;
  logic [HALF-1:0] diff_lo_s;
  logic            c_mid_s;
  logic            s1_valid_r;
  logic [HALF-1:0] diff_lo_r;
  logic            c_mid_r;
  logic [HALF-1:0] a_hi_r;
  logic [HALF-1:0] b_hi_r;

  // Stage 2 datapath and registers
  logic [HALF-1:0] b_hi_inv_s;
  logic [HALF-1:0] diff_hi_s;
  logic            c_out_s;
  logic            s2_valid_r;
  logic [WIDTH:0]  result_r;

  // Stage 1 may move on when stage 2 is empty or is being drained this cycle.
  assign s1_adv_s = !s2_valid_r || i_ready;
  assign o_ready  = !s1_valid_r || s1_adv_s;
  assign accept_s = i_valid && o_ready;

  assign b_lo_inv_s = ~i_sub[HALF-1:0];
  assign b_hi_inv_s = ~b_hi_r;

  cla_block #(.N(HALF)) u_cla_lo (
    .i_a    (i_min[HALF-1:0]),
    .i_b    (b_lo_inv_s),
    .i_cin  (1'b1),
    .o_sum  (diff_lo_s),
    .o_cout (c_mid_s)
  );

  cla_block #(.N(HALF)) u_cla_hi (
    .i_a    (a_hi_r),
    .i_b    (b_hi_inv_s),
    .i_cin  (c_mid_r),
    .o_sum  (diff_hi_s),
    .o_cout (c_out_s)
  );

  // Stage 1: capture low-half difference, mid carry and upper operand halves on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_r <= 1'b0;
      diff_lo_r  <= '0;
      c_mid_r    <= 1'b0;
      a_hi_r     <= '0;
      b_hi_r     <= '0;
    end else begin
      if (o_ready) begin
        s1_valid_r <= accept_s;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
      if (accept_s) begin
        diff_lo_r <= diff_lo_s;
        c_mid_r   <= c_mid_s;
        a_hi_r    <= i_min[WIDTH-1:HALF];
        b_hi_r    <= i_sub[WIDTH-1:HALF];
      end
    end
  end

  // Stage 2: finish the upper half and register {borrow, difference}; hold while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_r <= 1'b0;
      result_r   <= '0;
    end else if (s1_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= {borrow_from_carry(c_out_s), diff_hi_s, diff_lo_r};
      end
    end
  end

  assign o_valid  = s2_valid_r;
  assign o_result = result_r;

`ifdef CLA_SUB_OVF_EN
  logic ovf_r;

  // Signed overflow: operands of opposite sign and result sign differs from the minuend.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_r <= 1'b0;
    end else if (s1_adv_s && s1_valid_r) begin
      ovf_r <= (a_hi_r[HALF-1] != b_hi_r[HALF-1]) && (diff_hi_s[HALF-1] != a_hi_r[HALF-1]);
    end
  end

  assign o_ovf = ovf_r;
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_sub_pipe_24bit.sv
// Self-checking bench for cla_sub_pipe_24bit: directed vectors with hand-computed
// results plus a random handshake scoreboard.
module tb_cla_sub_pipe_24bit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_min;
  logic [23:0] i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [24:0] o_result;
  logic        o_ovf;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef CLA_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  cla_sub_pipe_24bit #(.WIDTH(24)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_min    (i_min),
    .i_sub    (i_sub),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_ovf    (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  // Reference: {ovf, borrow, diff}
  function automatic logic [25:0] model(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] d;
    logic        borrow;
    logic        ovf;
    d      = a - b;
    borrow = (a < b);
    ovf    = OVF_ON && (a[23] != b[23]) && (d[23] != a[23]);
    return {ovf, borrow, d};
  endfunction

  // Send one pair with i_ready high and wait (bounded) for its result.
  task automatic run_one(input logic [23:0] a, input logic [23:0] b,
                         output logic [24:0] res, output logic ovf, output logic ok);
    ok      = 1'b0;
    res     = '0;
    ovf     = 1'b0;
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_min   = a;
    i_sub   = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!ok && o_valid) begin
        ok  = 1'b1;
        res = o_result;
        ovf = o_ovf;
      end
      if (!ok) begin
        @(posedge i_clk); #1;
      end
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_min   = 24'h000000;
    i_sub   = 24'h000000;
    repeat (2) @(posedge i_clk);
    #1;
    tests_run++;
    if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    tests_run++;
    if (o_result !== 25'h0000000) begin tests_failed++; $display("FAIL reset_result got=%h exp=0", o_result); end
    tests_run++;
    if (o_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got=%b exp=0", o_ovf); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    tests_run++;
    if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_min   = 24'h000005;
    i_sub   = 24'h000003;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    tests_run++;
    if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early got=%b exp=0", o_valid); end
    @(posedge i_clk); #1;
    tests_run++;
    if (o_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_latency got=%b exp=1", o_valid); end
    tests_run++;
    if (o_result !== 25'h0000002) begin tests_failed++; $display("FAIL basic_result got=%h exp=0000002", o_result); end
    @(posedge i_clk); #1;
    tests_run++;
    if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_dup got=%b exp=0", o_valid); end
  endtask

  task automatic test_boundary();
    logic [24:0] res;
    logic        ovf;
    logic        ok;
    run_one(24'h000000, 24'hFFFFFF, res, ovf, ok);
    tests_run++;
    if (!ok || res !== 25'h1000001) begin tests_failed++; $display("FAIL zero_minus_max got=%h ok=%b exp=1000001", res, ok); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL zero_minus_max_ovf got=%b exp=0", ovf); end
    run_one(24'h800000, 24'h000001, res, ovf, ok);
    tests_run++;
    if (!ok || res !== 25'h07FFFFF) begin tests_failed++; $display("FAIL min_neg_minus_one got=%h ok=%b exp=07FFFFF", res, ok); end
    tests_run++;
    if (ovf !== OVF_ON) begin tests_failed++; $display("FAIL min_neg_minus_one_ovf got=%b exp=%b", ovf, OVF_ON); end
  endtask

  task automatic test_mid_carry();
    logic [24:0] res;
    logic        ovf;
    logic        ok;
    run_one(24'h001000, 24'h000001, res, ovf, ok);
    tests_run++;
    if (!ok || res !== 25'h0000FFF) begin tests_failed++; $display("FAIL mid_carry got=%h ok=%b exp=0000FFF", res, ok); end
    run_one(24'h123456, 24'h123456, res, ovf, ok);
    tests_run++;
    if (!ok || res !== 25'h0000000) begin tests_failed++; $display("FAIL equal_ops got=%h ok=%b exp=0000000", res, ok); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] va [8];
    logic [23:0] vb [8];
    logic [24:0] ve [8];
    va = '{24'h000010, 24'h000003, 24'hFFFFFF, 24'h000FFF, 24'h001000, 24'h7FFFFF, 24'h000000, 24'hABCDEF};
    vb = '{24'h000001, 24'h000005, 24'h000001, 24'h001000, 24'h000FFF, 24'h800000, 24'h000000, 24'h012345};
    ve = '{25'h000000F, 25'h1FFFFFE, 25'h0FFFFFE, 25'h1FFFFFF, 25'h0000001, 25'h1FFFFFF, 25'h0000000, 25'h0AAAAAA};
    i_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      i_valid = (c < 8);
      i_min   = (c < 8) ? va[c] : 24'h000000;
      i_sub   = (c < 8) ? vb[c] : 24'h000000;
      #1;
      if (c < 8) begin
        tests_run++;
        if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, o_ready); end
      end
      @(posedge i_clk); #1;
      tests_run++;
      if (c < 8) begin
        if (o_valid !== 1'b1 && c >= 1) begin tests_failed++; $display("FAIL b2b_valid c=%0d got=%b exp=1", c, o_valid); end
        else if (c >= 1 && o_result !== ve[c-1]) begin tests_failed++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", c-1, o_result, ve[c-1]); end
        else if (c == 0 && o_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_first c=0 got=%b exp=0", o_valid); end
      end else if (c == 8) begin
        if (o_valid !== 1'b1 || o_result !== ve[7]) begin tests_failed++; $display("FAIL b2b_last got=%h v=%b exp=%h", o_result, o_valid, ve[7]); end
      end else begin
        if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_extra c=%0d got=%b exp=0", c, o_valid); end
      end
    end
  endtask

  task automatic test_stall();
    logic [24:0] ve [3];
    int got;
    ve = '{25'h0000064, 25'h1FFFFFF, 25'h0123456};
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_min = 24'h0000C8; i_sub = 24'h000064;
    @(posedge i_clk); #1;
    i_min = 24'h000000; i_sub = 24'h000001;
    @(posedge i_clk); #1;
    i_min = 24'h123456; i_sub = 24'h000000;
    tests_run++;
    if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready got=%b exp=0", o_ready); end
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk); #1;
      tests_run++;
      if (o_valid !== 1'b1 || o_result !== ve[0] || o_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold k=%0d got=%h v=%b r=%b exp=%h", k, o_result, o_valid, o_ready, ve[0]);
      end
    end
    i_ready = 1'b1;
    #1;
    tests_run++;
    if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready got=%b exp=1", o_ready); end
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_valid) begin
        tests_run++;
        if (got >= 3) begin tests_failed++; $display("FAIL stall_drain_extra got=%h exp=none", o_result); end
        else if (o_result !== ve[got]) begin tests_failed++; $display("FAIL stall_drain idx=%0d got=%h exp=%h", got, o_result, ve[got]); end
        got++;
      end
      @(posedge i_clk); #1;
      i_valid = 1'b0;
    end
    tests_run++;
    if (got != 3) begin tests_failed++; $display("FAIL stall_count got=%0d exp=3", got); end
  endtask

  task automatic test_reset_flight();
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_min = 24'h000009; i_sub = 24'h000002;
    @(posedge i_clk); #1;
    i_min = 24'h000004; i_sub = 24'h000001;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    tests_run++;
    if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_async_valid got=%b exp=0", o_valid); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk); #1;
      tests_run++;
      if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_stale k=%0d got=%b exp=0", k, o_valid); end
    end
  endtask

  task automatic test_random();
    logic [25:0] sb_q [$];
    logic [25:0] exp_v;
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_min   = $urandom;
      i_sub   = $urandom;
      if ($urandom_range(0, 9) == 0) i_sub = i_min;
      #1;
      if (o_valid && i_ready) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_spurious got=%h exp=none", o_result);
        end else begin
          exp_v = sb_q.pop_front();
          if ({o_ovf, o_result} !== exp_v) begin
            tests_failed++;
            $display("FAIL rand_result got=%h exp=%h", {o_ovf, o_result}, exp_v);
          end
        end
      end
      if (i_valid && o_ready) sb_q.push_back(model(i_min, i_sub));
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (o_valid) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_drain_spurious got=%h exp=none", o_result);
        end else begin
          exp_v = sb_q.pop_front();
          if ({o_ovf, o_result} !== exp_v) begin
            tests_failed++;
            $display("FAIL rand_drain got=%h exp=%h", {o_ovf, o_result}, exp_v);
          end
        end
      end
      @(posedge i_clk); #1;
    end
    tests_run++;
    if (sb_q.size() != 0) begin tests_failed++; $display("FAIL rand_lost got=%0d exp=0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_mid_carry();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
